ema_signal_engine: RTL

Streaming Q16.16 signal stage that sits directly upstream of the risk/limit check. It accepts a price tick stream and keeps a running EMA with alpha = 2^-ALPHA_SHIFT. For each tick it produces a weighted signal, W1*deviation + W2*momentum, plus a risk flag that compares |signal| against LIMIT. The datapath is a 3-stage pipeline with valid/ready handshakes on both sides and full back-pressure.

---
 rtl/fxp_pkg.sv | 40 ++++
 rtl/ema_signal_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fxp_pkg.sv
// Q16.16 fixed-point helpers and default tuning for the EMA signal engine.
// Contents: fxp_t word type, saturation limits, engine parameter defaults,
// fxp_sat32 (34-bit signed -> saturated fxp_t) and fxp_abs_sat.
package fxp_pkg;

    typedef logic signed [31:0] fxp_t;

    localparam fxp_t FXP_MAX = 32'sh7FFF_FFFF;
    localparam fxp_t FXP_MIN = 32'sh8000_0000;

    localparam int unsigned FXP_FRAC        = 16;
    localparam int unsigned FXP_ALPHA_SHIFT = 5;
    localparam fxp_t        FXP_W1          = 32'sd49152;   // 0.75
    localparam fxp_t        FXP_W2          = 32'sd16384;   // 0.25
    localparam fxp_t        FXP_LIMIT       = 32'sd131072;  // 2.0

    // Clamp a 34-bit signed value into the 32-bit range; it fits when the
    // top three bits agree.
    function automatic fxp_t fxp_sat32(input logic signed [33:0] v);
        if ((v[33:31] == 3'b000) || (v[33:31] == 3'b111)) begin
            return fxp_t'(v[31:0]);
        end else if (v[33]) begin
            return FXP_MIN;
        end else begin
            return FXP_MAX;
        end
    endfunction

    // Magnitude with the most negative value pinned to FXP_MAX.
    function automatic fxp_t fxp_abs_sat(input fxp_t v);
        if (v == FXP_MIN) begin
            return FXP_MAX;
        end else if (v[31]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/ema_signal_engine.sv
// Streaming Q16.16 EMA signal stage feeding the risk/limit check.
// Three pipeline banks (S1 dev/mom/EMA, S2 weighted products, S3 saturated
// sum + risk flag) share one stall enable for full back-pressure.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clear               synchronous soft clear (un-prime, flush pipeline)
//   in_valid/in_ready   tick handshake, in_price signed Q16.16
//   out_valid/out_ready result handshake
//   out_signal          saturated W1*dev + W2*mom
//   out_ema             EMA after this tick's update
//   out_risk            |out_signal| > LIMIT
//   primed              EMA has been seeded
module ema_signal_engine
    import fxp_pkg::*;
#(
    parameter int unsigned FRAC        = FXP_FRAC,
    parameter int unsigned ALPHA_SHIFT = FXP_ALPHA_SHIFT,
    parameter fxp_t        W1          = FXP_W1,
    parameter fxp_t        W2          = FXP_W2,
    parameter fxp_t        LIMIT       = FXP_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_price,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_signal,
    output logic [31:0] out_ema,
    output logic        out_risk,
    output logic        primed
);

    // State and pipeline registers
    fxp_t              ema_q,  ema_d;
    fxp_t              prev_q, prev_d;
    logic              primed_q, primed_d;
    logic              rdy_en_q;
    logic              v1_q, v1_d;
    fxp_t              dev_q, dev_d, mom_q, mom_d, ema1_q, ema1_d;
    logic              v2_q, v2_d;
    logic signed [32:0] p1_q, p1_d, p2_q, p2_d;
    fxp_t              ema2_q, ema2_d;
    logic              v3_q, v3_d;
    fxp_t              sig_q, sig_d, ema3_q, ema3_d;
    logic              risk_q, risk_d;

    // Datapath wires
    fxp_t               price;
    logic               stall, accept;
    logic signed [32:0] dev_w, mom_w;
    fxp_t               dev_s, mom_s, ema_upd;
    logic signed [63:0] prod1, prod2;
    logic signed [33:0] sum_w;
    fxp_t               sig_s;

    assign price  = in_price;
    assign stall  = v3_q && !out_ready;
    // rdy_en_q keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_en_q && !stall && !clear;
    assign accept = in_valid && in_ready;

    // S1: deviation / momentum at 33 bits, then saturate
    assign dev_w   = 33'(price) - 33'(ema_q);
    assign mom_w   = 33'(price) - 33'(prev_q);
    assign dev_s   = fxp_sat32(34'(dev_w));
    assign mom_s   = fxp_sat32(34'(mom_w));
    assign ema_upd = ema_q + (dev_s >>> ALPHA_SHIFT);

    // S2: full-width signed products, floored by the arithmetic shift
    assign prod1 = 64'(W1) * 64'(dev_q);
    assign prod2 = 64'(W2) * 64'(mom_q);

    // S3: 34-bit sum then saturate
    assign sum_w = 34'(p1_q) + 34'(p2_q);
    assign sig_s = fxp_sat32(sum_w);

    // Next-state: clear wins, stall freezes everything, else advance
    always_comb begin
        ema_d    = ema_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        v1_d     = v1_q;
        dev_d    = dev_q;
        mom_d    = mom_q;
        ema1_d   = ema1_q;
        v2_d     = v2_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        ema2_d   = ema2_q;
        v3_d     = v3_q;
        sig_d    = sig_q;
        ema3_d   = ema3_q;
        risk_d   = risk_q;

        if (clear) begin
            primed_d = 1'b0;
            v1_d     = 1'b0;
            v2_d     = 1'b0;
            v3_d     = 1'b0;
            ema_d    = '0;
            prev_d   = '0;
        end else if (!stall) begin
            // Seeding tick updates state but never enters the pipeline
            v1_d = accept && primed_q;
            v2_d = v1_q;
            v3_d = v2_q;

            if (accept) begin
                prev_d = price;
                if (primed_q) begin
                    ema_d  = ema_upd;
                    dev_d  = dev_s;
                    mom_d  = mom_s;
                    ema1_d = ema_upd;
                end else begin
                    ema_d    = price;
                    primed_d = 1'b1;
                end
            end

            if (v1_q) begin
                p1_d   = 33'(prod1 >>> FRAC);
                p2_d   = 33'(prod2 >>> FRAC);
                ema2_d = ema1_q;
            end

            if (v2_q) begin
                sig_d  = sig_s;
                ema3_d = ema2_q;
                risk_d = fxp_abs_sat(sig_s) > LIMIT;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ema_q    <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            rdy_en_q <= 1'b0;
            v1_q     <= 1'b0;
            dev_q    <= '0;
            mom_q    <= '0;
            ema1_q   <= '0;
            v2_q     <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            ema2_q   <= '0;
            v3_q     <= 1'b0;
            sig_q    <= '0;
            ema3_q   <= '0;
            risk_q   <= 1'b0;
        end else begin
            ema_q    <= ema_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            rdy_en_q <= 1'b1;
            v1_q     <= v1_d;
            dev_q    <= dev_d;
            mom_q    <= mom_d;
            ema1_q   <= ema1_d;
            v2_q     <= v2_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            ema2_q   <= ema2_d;
            v3_q     <= v3_d;
            sig_q    <= sig_d;
            ema3_q   <= ema3_d;
            risk_q   <= risk_d;
        end
    end

    assign out_valid  = v3_q;
    assign out_signal = sig_q;
    assign out_ema    = ema3_q;
    assign out_risk   = risk_q;
    assign primed     = primed_q;

endmodule
